boot_loader_ctrl: RTL
=====================

// Module: boot_loader_ctrl
// PURPOSE
// Boot sequencer for the rv32i single-cycle core. Accepts a 32-bit word stream (valid/ready),
// writes a data image into data BRAM and a program image into instruction BRAM, then releases
// the core: hands the data BRAM write port to the core, deasserts core reset, unstalls the PC,
// and enables instruction and register reads. Also stops the core on a cycle budget or a halt request.
// PARAMETERS
// DATA_WIDTH  32    stream and BRAM word width
// ADDR_WIDTH  12    BRAM byte-address width
// I_DEPTH     1024  max instruction words
// D_DEPTH     1024  max data words
// RUN_CYCLES  0     core run budget in cycles; 0 = unlimited
// PORTS
// clk           in   1           clock
// rst           in   1           asynchronous, active-high reset
// start         in   1           pulse; begin (re)load; honoured only in IDLE, DONE, ERR
// halt          in   1           level; stop core while in RUN
// s_dat         in   DATA_WIDTH  stream word
// s_valid       in   1           stream word valid
// s_ready       out  1           loader accepts word (transfer = s_valid & s_ready)
// d_w_addr      out  ADDR_WIDTH  data BRAM write byte address
// d_w_dat       out  DATA_WIDTH  data BRAM write data
// d_w_enb       out  1           data BRAM write enable
// d_w_byte_enb  out  4           data BRAM byte enables
// i_w_addr      out  ADDR_WIDTH  instruction BRAM write byte address
// i_w_dat       out  DATA_WIDTH  instruction BRAM write data
// i_w_enb       out  1           instruction BRAM write enable
// i_w_byte_enb  out  4           instruction BRAM byte enables
// d_bram_init_done out 1         1 = core owns data BRAM write port
// cpu_rst       out  1           reset to pc/regfile/BRAM read side
// pc_stall      out  1           PC stall
// i_r_enb       out  1           instruction BRAM read enable
// rd_enbl       out  1           register file read enable
// error         out  1           bad header seen; sticky until start or rst
// state         out  3           FSM state encoding, for debug
// BEHAVIOUR
// - All outputs registered. Reset: state=IDLE, cpu_rst=1, pc_stall=1; every other output 0.
// - States: IDLE=0, HDR=1, LOAD_D=2, LOAD_I=3, RELEASE=4, RUN=5, DONE=6, ERR=7.
// - IDLE: start -> HDR. DONE/ERR: start -> HDR, clears error/init_done, reasserts cpu_rst, pc_stall.
// - s_ready=1 only in HDR, LOAD_D, LOAD_I; one word accepted per cycle max.
// - HDR word: [15:0]=n_instr, [31:16]=n_data. n_instr==0, n_instr>I_DEPTH or n_data>D_DEPTH -> ERR.
//   Otherwise -> LOAD_D, or -> LOAD_I directly if n_data==0.
// - LOAD_D: k-th accepted word (k from 0) drives d_w_enb=1, d_w_addr=k*4, byte_enb=4'hF on the next
//   cycle, for exactly one cycle. After word n_data-1 is accepted -> LOAD_I. LOAD_I is identical on the i_w_* ports.
// - Index counters reset to 0 on HDR entry; addresses wrap modulo 2^ADDR_WIDTH (unreachable when depths are legal).
// - After word n_instr-1 is accepted -> RELEASE. The last write strobe issues during the RELEASE cycle.
// - RELEASE (1 cycle): cpu_rst->0; pc_stall remains 1. Transitions unconditionally -> RUN.
// - RUN: pc_stall=0, i_r_enb=1, rd_enbl=1. d_bram_init_done=1 from RUN entry until the next start or rst.
// - RUN exit -> DONE when halt=1, or when run counter == RUN_CYCLES-1 (RUN_CYCLES>0). Counter clears on RUN entry.
// - DONE: pc_stall=1, i_r_enb=0, cpu_rst=0. Core state stays visible; d_bram_init_done stays 1 for debug reads.
// - ERR: error=1, s_ready=0, cpu_rst=1, pc_stall=1. No BRAM write issues in ERR.
// - start outside IDLE/DONE/ERR is ignored. halt outside RUN is ignored.
// - s_valid low mid-load: FSM waits; no write strobes; no timeout.
// - rst mid-load: immediate return to IDLE; partial image discarded; write enables drop asynchronously.
// TESTING
// - Header n_data=4, n_instr=14, words streamed back-to-back -> 4 d_w_enb pulses at 0x0..0xC, then
//   14 i_w_enb pulses at 0x0..0x34. The core then runs the beq/bne program: x7=6, mem[0xC]=6.
// - s_valid toggles 1/0 every cycle during load -> same BRAM contents; write pulses only follow accepted words.
// - Header n_instr=0, or n_data=D_DEPTH+1 -> ERR, error=1, no write strobe. A following start reloads cleanly.
// - RUN_CYCLES=20 -> pc_stall rises exactly 20 cycles after RUN entry. halt=1 at cycle 5 -> DONE next cycle.
// - rst pulsed after 2 data words -> IDLE, all enables 0, cpu_rst=1. Restart loads the full image correctly.
// - n_data=0 -> HDR goes straight to LOAD_I, no d_w_enb pulse. start while in RUN -> ignored.

Source files
------------

// File: rtl/boot_loader_ctrl.sv
// rtl/boot_loader_ctrl.sv - boot sequencer: streams data/instruction images into BRAM, then releases the core
// Header word selects image sizes; all outputs are registered from the next-state value.
module boot_loader_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int I_DEPTH    = 1024,
  parameter int D_DEPTH    = 1024,
  parameter int RUN_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  halt,
  input  logic [DATA_WIDTH-1:0] s_dat,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] d_w_addr,
  output logic [DATA_WIDTH-1:0] d_w_dat,
  output logic                  d_w_enb,
  output logic [3:0]            d_w_byte_enb,
  output logic [ADDR_WIDTH-1:0] i_w_addr,
  output logic [DATA_WIDTH-1:0] i_w_dat,
  output logic                  i_w_enb,
  output logic [3:0]            i_w_byte_enb,
  output logic                  d_bram_init_done,
  output logic                  cpu_rst,
  output logic                  pc_stall,
  output logic                  i_r_enb,
  output logic                  rd_enbl,
  output logic                  error,
  output logic [2:0]            state
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_LOAD_D  = 3'd2,
    ST_LOAD_I  = 3'd3,
    ST_RELEASE = 3'd4,
    ST_RUN     = 3'd5,
    ST_DONE    = 3'd6,
    ST_ERR     = 3'd7
  } state_t;

  localparam logic [16:0] I_MAX    = 17'(I_DEPTH);
  localparam logic [16:0] D_MAX    = 17'(D_DEPTH);
  localparam logic [31:0] RUN_LAST = 32'(RUN_CYCLES - 1);

  state_t                  r_state;
  logic [15:0]             r_n_instr;
  logic [15:0]             r_n_data;
  logic [15:0]             r_idx;
  logic [31:0]             r_run_cnt;
  logic                    r_s_ready;
  logic [ADDR_WIDTH-1:0]   r_d_w_addr;
  logic [DATA_WIDTH-1:0]   r_d_w_dat;
  logic                    r_d_w_enb;
  logic [3:0]              r_d_w_byte_enb;
  logic [ADDR_WIDTH-1:0]   r_i_w_addr;
  logic [DATA_WIDTH-1:0]   r_i_w_dat;
  logic                    r_i_w_enb;
  logic [3:0]              r_i_w_byte_enb;
  logic                    r_init_done;
  logic                    r_cpu_rst;
  logic                    r_pc_stall;
  logic                    r_i_r_enb;
  logic                    r_rd_enbl;
  logic                    r_error;

  state_t                  w_next;
  logic                    w_xfer;
  logic                    w_start_ok;
  logic [15:0]             w_hdr_ni;
  logic [15:0]             w_hdr_nd;
  logic                    w_hdr_bad;
  logic                    w_run_last;
  logic                    w_last_d;
  logic                    w_last_i;
  logic [ADDR_WIDTH-1:0]   w_idx_addr;
  logic                    w_next_ready;

  // r_s_ready is only ever set for the three accepting states, so it doubles as the state qualifier.
  assign w_xfer     = s_valid & r_s_ready;
  assign w_start_ok = start & ((r_state == ST_IDLE) | (r_state == ST_DONE) | (r_state == ST_ERR));
  assign w_hdr_ni   = s_dat[15:0];
  assign w_hdr_nd   = s_dat[31:16];
  assign w_hdr_bad  = (w_hdr_ni == 16'd0) || ({1'b0, w_hdr_ni} > I_MAX) || ({1'b0, w_hdr_nd} > D_MAX);
  assign w_run_last = (RUN_CYCLES > 0) && (r_run_cnt == RUN_LAST);
  assign w_last_d   = (r_idx == r_n_data - 16'd1);
  assign w_last_i   = (r_idx == r_n_instr - 16'd1);
  assign w_idx_addr = {r_idx[ADDR_WIDTH-3:0], 2'b00};

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_start_ok) w_next = ST_HDR;
      ST_HDR: begin
        if (w_xfer) begin
          if (w_hdr_bad)               w_next = ST_ERR;
          else if (w_hdr_nd == 16'd0)  w_next = ST_LOAD_I;
          else                         w_next = ST_LOAD_D;
        end
      end
      ST_LOAD_D:  if (w_xfer && w_last_d) w_next = ST_LOAD_I;
      ST_LOAD_I:  if (w_xfer && w_last_i) w_next = ST_RELEASE;
      ST_RELEASE: w_next = ST_RUN;
      ST_RUN:     if (halt || w_run_last) w_next = ST_DONE;
      ST_DONE:    if (w_start_ok) w_next = ST_HDR;
      ST_ERR:     if (w_start_ok) w_next = ST_HDR;
      default:    w_next = ST_IDLE;
    endcase
  end

  assign w_next_ready = (w_next == ST_HDR) || (w_next == ST_LOAD_D) || (w_next == ST_LOAD_I);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_n_instr      <= '0;
      r_n_data       <= '0;
      r_idx          <= '0;
      r_run_cnt      <= '0;
      r_s_ready      <= 1'b0;
      r_d_w_addr     <= '0;
      r_d_w_dat      <= '0;
      r_d_w_enb      <= 1'b0;
      r_d_w_byte_enb <= 4'h0;
      r_i_w_addr     <= '0;
      r_i_w_dat      <= '0;
      r_i_w_enb      <= 1'b0;
      r_i_w_byte_enb <= 4'h0;
      r_init_done    <= 1'b0;
      r_cpu_rst      <= 1'b1;
      r_pc_stall     <= 1'b1;
      r_i_r_enb      <= 1'b0;
      r_rd_enbl      <= 1'b0;
      r_error        <= 1'b0;
    end else begin
      r_state        <= w_next;
      r_s_ready      <= w_next_ready;
      r_d_w_enb      <= 1'b0;
      r_d_w_byte_enb <= 4'h0;
      r_i_w_enb      <= 1'b0;
      r_i_w_byte_enb <= 4'h0;

      case (r_state)
        ST_HDR: begin
          if (w_xfer) begin
            r_n_instr <= w_hdr_ni;
            r_n_data  <= w_hdr_nd;
          end
        end
        ST_LOAD_D: begin
          if (w_xfer) begin
            r_d_w_enb      <= 1'b1;
            r_d_w_addr     <= w_idx_addr;
            r_d_w_dat      <= s_dat;
            r_d_w_byte_enb <= 4'hF;
            r_idx          <= w_last_d ? 16'd0 : r_idx + 16'd1;
          end
        end
        ST_LOAD_I: begin
          if (w_xfer) begin
            r_i_w_enb      <= 1'b1;
            r_i_w_addr     <= w_idx_addr;
            r_i_w_dat      <= s_dat;
            r_i_w_byte_enb <= 4'hF;
            r_idx          <= r_idx + 16'd1;
          end
        end
        ST_RUN:  r_run_cnt <= r_run_cnt + 32'd1;
        default: ;
      endcase

      if (w_next == ST_HDR && r_state != ST_HDR) r_idx <= '0;
      if (w_next == ST_RUN && r_state != ST_RUN) r_run_cnt <= '0;

      r_cpu_rst  <= !((w_next == ST_RELEASE) || (w_next == ST_RUN) || (w_next == ST_DONE));
      r_pc_stall <= (w_next != ST_RUN);
      r_i_r_enb  <= (w_next == ST_RUN);
      r_rd_enbl  <= (w_next == ST_RUN);
      r_error    <= (w_next == ST_ERR);
      // Ownership of the data BRAM stays with the core through DONE so its memory remains inspectable.
      if (w_next == ST_RUN)      r_init_done <= 1'b1;
      else if (w_next == ST_HDR) r_init_done <= 1'b0;
    end
  end

  assign state            = r_state;
  assign s_ready          = r_s_ready;
  assign d_w_addr         = r_d_w_addr;
  assign d_w_dat          = r_d_w_dat;
  assign d_w_enb          = r_d_w_enb;
  assign d_w_byte_enb     = r_d_w_byte_enb;
  assign i_w_addr         = r_i_w_addr;
  assign i_w_dat          = r_i_w_dat;
  assign i_w_enb          = r_i_w_enb;
  assign i_w_byte_enb     = r_i_w_byte_enb;
  assign d_bram_init_done = r_init_done;
  assign cpu_rst          = r_cpu_rst;
  assign pc_stall         = r_pc_stall;
  assign i_r_enb          = r_i_r_enb;
  assign rd_enbl          = r_rd_enbl;
  assign error            = r_error;

endmodule
